// File: rtl/pla_seq_eval.sv
// Programmable sum-of-products evaluator: loadable cube table scanned LANES cubes per
// cycle against one translated input vector, with valid/ready handshakes on both sides.
module pla_seq_eval #(
   parameter int N_IN       = 9,
   parameter int N_OUT      = 1,
   parameter int N_CUBES    = 64,
   parameter int LANES      = 4,
   parameter int EARLY_EXIT = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_we,
   input  logic [$clog2(N_CUBES)-1:0] cfg_addr,
   input  logic [N_IN-1:0]            cfg_care,
   input  logic [N_IN-1:0]            cfg_val,
   input  logic [N_OUT-1:0]           cfg_out,
   input  logic                       shift_we,
   input  logic [N_IN-1:0]            shift_vec,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_IN-1:0]            in_x,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_OUT-1:0]           out_y,
   output logic                       busy
);

   localparam int B  = N_CUBES / LANES;
   localparam int AW = $clog2(N_CUBES);
   localparam int BW = (B > 1) ? $clog2(B) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state_q, state_nxt;
   logic [BW-1:0]     beat_q;
   logic [N_OUT-1:0]  acc_q;
   logic [N_OUT-1:0]  acc_nxt;
   logic [N_OUT-1:0]  beat_hit;
   logic [N_IN-1:0]   xs_q;
   logic [N_IN-1:0]   shift_q;
   logic [N_IN-1:0]   care_q [N_CUBES];
   logic [N_IN-1:0]   val_q  [N_CUBES];
   logic [N_OUT-1:0]  out_q  [N_CUBES];
   logic [AW-1:0]     idx;
   logic              accept;
   logic              last_beat;
   logic              saturated;

   assign accept    = in_valid && (state_q == IDLE);
   assign last_beat = (beat_q == BW'(B - 1));
   assign acc_nxt   = acc_q | beat_hit;
   assign saturated = (EARLY_EXIT != 0) && (&acc_nxt);

   // Matches of the LANES cubes addressed by the current beat
   always_comb begin
      beat_hit = '0;
      idx      = '0;
      for (int l = 0; l < LANES; l++) begin
         idx = AW'(int'(beat_q) * LANES + l);
         if ((xs_q & care_q[idx]) == (val_q[idx] & care_q[idx]))
            beat_hit = beat_hit | out_q[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (in_valid)                state_nxt = SCAN;
         SCAN:    if (last_beat || saturated)  state_nxt = DONE;
         DONE:    if (out_ready)               state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
         acc_q  <= '0;
      end else if (accept) begin
         beat_q <= '0;
         acc_q  <= '0;
      end else if (state_q == SCAN) begin
         acc_q <= acc_nxt;
         if (!last_beat) beat_q <= beat_q + BW'(1);
      end
   end

   // Translated vector is captured with the shift value in force before any same-cycle write
   always_ff @(posedge clk) begin
      if (accept) xs_q <= in_x ^ shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         for (int k = 0; k < N_CUBES; k++) begin
            care_q[k] <= '0;
            val_q[k]  <= '0;
            out_q[k]  <= '0;
         end
      end else if (!busy) begin
         if (shift_we) shift_q <= shift_vec;
         if (cfg_we) begin
            care_q[cfg_addr] <= cfg_care;
            val_q[cfg_addr]  <= cfg_val;
            out_q[cfg_addr]  <= cfg_out;
         end
      end
   end

   assign out_y = acc_q;

endmodule

// File: tb/tb_pla_seq_eval.sv
// Bench for pla_seq_eval: a default instance and a two-output early-exit instance,
// both checked against a cube-table reference model.
module tb_pla_seq_eval;

   localparam int NC = 64;
   localparam int LN = 4;
   localparam int B  = NC / LN;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] cfg_addr;
   logic [8:0] cfg_care, cfg_val, shift_vec, in_x;
   logic [1:0] c_out;
   logic       a_cfg_we, a_shift_we, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [0:0] a_out_y;
   logic       b_cfg_we, b_shift_we, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [1:0] b_out_y;

   int total = 0;
   int bad   = 0;
   int cur   = 0;

   logic [8:0] mc [2][NC];
   logic [8:0] mv [2][NC];
   logic [1:0] mo [2][NC];
   logic [8:0] msh [2];

   logic       s_ov, s_ir, s_busy;
   logic [1:0] s_oy;
   assign s_ov   = (cur != 0) ? b_out_valid : a_out_valid;
   assign s_ir   = (cur != 0) ? b_in_ready  : a_in_ready;
   assign s_busy = (cur != 0) ? b_busy      : a_busy;
   assign s_oy   = (cur != 0) ? b_out_y     : {1'b0, a_out_y};

   always #5 clk = ~clk;

   pla_seq_eval dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_we(a_cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
      .cfg_val(cfg_val), .cfg_out(c_out[0:0]), .shift_we(a_shift_we), .shift_vec(shift_vec),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(in_x), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_y(a_out_y), .busy(a_busy));

   pla_seq_eval #(.N_OUT(2), .EARLY_EXIT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_we(b_cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
      .cfg_val(cfg_val), .cfg_out(c_out), .shift_we(b_shift_we), .shift_vec(shift_vec),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(in_x), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_y(b_out_y), .busy(b_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         msh[d] = '0;
         for (int k = 0; k < NC; k++) begin
            mc[d][k] = '0;
            mv[d][k] = '0;
            mo[d][k] = '0;
         end
      end
   endtask

   function automatic logic cube_hit(input int d, input int k, input logic [8:0] x);
      logic [8:0] xs;
      xs = x ^ msh[d];
      return (xs & mc[d][k]) == (mv[d][k] & mc[d][k]);
   endfunction

   function automatic logic [1:0] model_y(input int d, input logic [8:0] x);
      logic [1:0] y;
      y = '0;
      for (int k = 0; k < NC; k++)
         if (cube_hit(d, k, x)) y = y | mo[d][k];
      return y;
   endfunction

   // Cycle (counting from 1 right after acceptance) in which out_valid is first seen
   function automatic int model_lat(input int d, input logic [8:0] x);
      logic [1:0] y;
      y = '0;
      if (d == 0) return B + 1;
      for (int j = 0; j < B; j++) begin
         for (int l = 0; l < LN; l++)
            if (cube_hit(d, j * LN + l, x)) y = y | mo[d][j * LN + l];
         if (y == 2'b11) return j + 2;
      end
      return B + 1;
   endfunction

   task automatic cfg_wr(input int d, input int addr, input logic [8:0] care,
                         input logic [8:0] val, input logic [1:0] o);
      cfg_addr = 6'(addr);
      cfg_care = care;
      cfg_val  = val;
      c_out    = o;
      if (d == 0) a_cfg_we = 1'b1; else b_cfg_we = 1'b1;
      step();
      a_cfg_we = 1'b0;
      b_cfg_we = 1'b0;
      mc[d][addr] = care;
      mv[d][addr] = val;
      mo[d][addr] = (d == 0) ? {1'b0, o[0]} : o;
   endtask

   task automatic set_shift(input int d, input logic [8:0] s);
      shift_vec = s;
      if (d == 0) a_shift_we = 1'b1; else b_shift_we = 1'b1;
      step();
      a_shift_we = 1'b0;
      b_shift_we = 1'b0;
      msh[d] = s;
   endtask

   // poke=1: pulse shift_we mid-scan; poke=2: pulse cfg_we to cube 0 while held in DONE
   task automatic run_vec(input int d, input logic [8:0] x, input int hold, input int poke);
      logic [1:0] ey;
      int         el;
      int         n;
      cur = d;
      ey  = model_y(d, x);
      el  = model_lat(d, x);
      chk("in_ready_idle", 32'(s_ir), 32'd1);
      in_x = x;
      if (d == 0) a_in_valid = 1'b1; else b_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      n = 1;
      while (!s_ov && n < 100) begin
         if (poke == 1 && n == 3) begin
            shift_vec = 9'h000;
            if (d == 0) a_shift_we = 1'b1; else b_shift_we = 1'b1;
         end
         step();
         a_shift_we = 1'b0;
         b_shift_we = 1'b0;
         n++;
      end
      chk("latency", 32'(n), 32'(el));
      chk("out_y", 32'(s_oy), 32'(ey));
      chk("busy_done", 32'(s_busy), 32'd1);
      for (int h = 0; h < hold; h++) begin
         if (poke == 2 && h == 1) begin
            cfg_addr = 6'd0;
            cfg_care = 9'h000;
            cfg_val  = 9'h000;
            c_out    = 2'b11;
            if (d == 0) a_cfg_we = 1'b1; else b_cfg_we = 1'b1;
         end
         step();
         a_cfg_we = 1'b0;
         b_cfg_we = 1'b0;
         chk("hold_y", 32'(s_oy), 32'(ey));
         chk("hold_valid", 32'(s_ov), 32'd1);
         chk("hold_in_ready", 32'(s_ir), 32'd0);
      end
      if (d == 0) a_out_ready = 1'b1; else b_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      chk("release_valid", 32'(s_ov), 32'd0);
      chk("release_in_ready", 32'(s_ir), 32'd1);
   endtask

   initial begin
      int  n;
      logic seen;
      rst_n = 1'b0;
      cfg_addr = '0; cfg_care = '0; cfg_val = '0; c_out = '0; shift_vec = '0; in_x = '0;
      a_cfg_we = 0; a_shift_we = 0; a_in_valid = 0; a_out_ready = 0;
      b_cfg_we = 0; b_shift_we = 0; b_in_valid = 0; b_out_ready = 0;
      model_clear();
      step();
      step();
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_y", 32'(a_out_y), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_b_out_y", 32'(b_out_y), 32'd0);
      rst_n = 1'b1;
      step();

      // Empty table
      run_vec(0, 9'h1FF, 0, 0);

      // Single cube, picked up on beat 9 by the early-exit instance
      cfg_wr(0, 37, 9'h0FF, 9'h03B, 2'b01);
      run_vec(0, 9'h13B, 0, 0);
      run_vec(0, 9'h03A, 0, 0);
      cfg_wr(1, 37, 9'h0FF, 9'h03B, 2'b11);
      run_vec(1, 9'h13B, 0, 0);

      // Translation, and a shift write during the scan is dropped
      set_shift(0, 9'h001);
      run_vec(0, 9'h03A, 0, 1);
      run_vec(0, 9'h03A, 0, 0);

      // Back-pressure with a dropped cube-0 write, then confirm cube 0 still disabled
      run_vec(0, 9'h03A, 5, 2);
      run_vec(0, 9'h000, 0, 0);

      // Early exit on beat 0
      cfg_wr(1, 2, 9'h000, 9'h000, 2'b11);
      run_vec(1, 9'(($urandom)), 0, 0);

      // Reset in the middle of a scan (beat 7)
      cur = 0;
      in_x = 9'h03A;
      a_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      n = 1;
      while (n < 8) begin
         step();
         n++;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(a_in_ready), 32'd1);
      chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
      chk("midrst_out_y", 32'(a_out_y), 32'd0);
      chk("midrst_busy", 32'(a_busy), 32'd0);
      model_clear();
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         seen = seen | a_out_valid;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);
      run_vec(0, 9'h03A, 0, 0);
      run_vec(1, 9'h13B, 0, 0);

      // Randomized tables, shifts and vectors on both instances
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++)
            cfg_wr(d, int'($urandom_range(0, NC - 1)), 9'($urandom & $urandom),
                   9'($urandom), 2'($urandom_range(0, 3)));
         set_shift(d, 9'($urandom));
         for (int i = 0; i < 12; i++)
            run_vec(d, 9'($urandom), int'($urandom_range(0, 2)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pla_seq_eval.md
# pla_seq_eval

Programmable, parametrised sum-of-products evaluator. It generalises the fixed single-output 9-input benchmark functions to a loadable cube table with N_IN inputs and N_OUT outputs. It evaluates one input vector at a time by scanning the table LANES cubes per cycle, behind valid/ready handshakes. An optional input-translation register (x ⊕ shift) allows autosymmetric functions to be evaluated from their reduced cover.

## Interface

Parameters:

- N_IN, 9: input variables per vector.
- N_OUT, 1: output functions.
- N_CUBES, 64: cube table depth; must be a multiple of LANES.
- LANES, 4: cubes evaluated per cycle.
- EARLY_EXIT, 0: when 1, the scan stops once every output bit is 1.

Ports:

- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  cube write strobe.
- cfg_addr  in  clog2(N_CUBES)  cube index.
- cfg_care  in  N_IN  care mask (1 = literal present).
- cfg_val  in  N_IN  literal polarity.
- cfg_out  in  N_OUT  outputs this cube feeds; all-zero disables the cube.
- shift_we  in  1  translation register write strobe.
- shift_vec  in  N_IN  translation vector.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_x  in  N_IN  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  N_OUT  result.
- busy  out  1  scan or result pending.

## Operation

- Cube k matches x when ((x ⊕ shift) & care[k]) == (val[k] & care[k]).
- out_y is the OR of cfg_out[k] over all matched k.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid&&in_ready: capture x⊕shift, clear the accumulator, beat=0, go to SCAN.
- SCAN:
  - Each cycle, OR the matches of cubes beat*LANES .. beat*LANES+LANES-1 into the accumulator.
  - beat runs 0..B-1, where B = N_CUBES/LANES.
  - After beat B-1, go to DONE.
  - If EARLY_EXIT=1 and the accumulator, including the current beat, is all ones: go to DONE immediately.
- DONE:
  - out_valid=1 and out_y = accumulator; both are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- Configuration writes (cfg_we, shift_we):
  - Applied only when busy=0.
  - Dropped silently when busy=1, so the table is stable during a scan.
  - A cfg write and an input acceptance in the same IDLE cycle: the write lands, and the accepted vector sees the new table. The shift captured with x is the pre-write value.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All cubes are cleared (care=0, val=0, out=0, i.e. disabled) and shift=0.
  - A scan in progress is discarded with no result.
- Reset values: in_ready=1, out_valid=0, out_y=0, busy=0.
- Widths: beat counter is clog2(B) bits and never wraps. With B=1 the SCAN state lasts exactly one cycle.

## Timing

- Acceptance edge: call it T0.
- SCAN occupies the cycles after T0 through T0+B.
- out_valid rises B+1 cycles after T0 (EARLY_EXIT=0), independent of data.
- With EARLY_EXIT=1, out_valid rises j+2 cycles after T0, where j is the first beat that saturates all outputs.
- Throughput: one vector per B+2 cycles with out_ready held high. This is one IDLE cycle, B SCAN cycles and one DONE cycle. IDLE is not skipped.
- in_ready is a registered state decode: no combinational path from in_valid or out_ready.
- out_y is registered.
- Back-pressure: DONE holds indefinitely while out_ready=0. in_ready stays 0 throughout.

## Test plan

- Reset state:
  - Stimulus: reset, then in_x=9'h1FF.
  - Required response: all cubes disabled, so out_y=0; out_valid 17 cycles after acceptance (defaults: B=16).
- Single cube:
  - Stimulus: cube 37 = care 9'h0FF, val 9'h03B, out 1. Apply x=9'h13B, then x=9'h03A.
  - Required response: 1, then 0.
  - Also check that cube 37 is picked up on beat 9.
- Translation:
  - Stimulus: same cube as above; shift=9'h001; x=9'h03A.
  - Required response: out_y=1.
  - Also: shift_we pulsed during SCAN is ignored; the next vector still uses 9'h001.
- Back-pressure and config lock:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE; pulse cfg_we to cube 0 meanwhile.
  - Required response: out_y is stable, in_ready=0, and cube 0 is unchanged. Verify with a follow-up vector.
- Early exit:
  - Stimulus: EARLY_EXIT=1, N_OUT=2; cube 2 drives 2'b11 and matches.
  - Required response: out_valid 2 cycles after acceptance, out_y=2'b11.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 at beat 7.
  - Required response: outputs go to reset values immediately, no out_valid pulse, and the table is cleared.
